// File: rtl/elevator_pkg.sv
// Shared types and sizing for the two-car hall-call dispatcher.
package elevator_pkg;
  localparam int NUM_FLOORS  = 64;
  localparam int FLOOR_IDX_W = $clog2(NUM_FLOORS);

  typedef enum logic [1:0] {ST_IDLE, ST_SELECT, ST_ISSUE} state_e;
  typedef enum logic {CAR1 = 1'b0, CAR2 = 1'b1} car_e;
endpackage

// File: rtl/elevator_dispatcher_floor_encoder.sv
// One-hot floor bus to binary index, with a flag that the bus had exactly one bit set.
module floor_encoder #(
  parameter int W  = 64,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  onehot_i,
  output logic [IW-1:0] idx_o,
  output logic          onehot_ok_o
);
  // OR of set-bit indices; only meaningful when onehot_ok_o is high
  always_comb begin
    idx_o = '0;
    for (int k = 0; k < W; k++)
      if (onehot_i[k]) idx_o = idx_o | IW'(k);
  end

  assign onehot_ok_o = (onehot_i != '0) && ((onehot_i & (onehot_i - W'(1))) == '0);
endmodule

// File: rtl/elevator_dispatcher.sv
// Collects hall calls into a pending bitmap and hands the lowest pending floor
// to the nearer eligible car, one assignment outstanding at a time.
module elevator_dispatcher
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  call_valid,
  input  logic [NUM_FLOORS-1:0] call_floor,
  input  logic [NUM_FLOORS-1:0] current_floor_elevator1,
  input  logic [NUM_FLOORS-1:0] current_floor_elevator2,
  input  logic                  idle_elevator1,
  input  logic                  idle_elevator2,
  input  logic                  in_emergency_elevator1,
  input  logic                  in_emergency_elevator2,
  output logic                  dispatch_valid_elevator1,
  output logic                  dispatch_valid_elevator2,
  output logic [NUM_FLOORS-1:0] dispatch_floor_elevator1,
  output logic [NUM_FLOORS-1:0] dispatch_floor_elevator2,
  input  logic                  dispatch_ack_elevator1,
  input  logic                  dispatch_ack_elevator2,
  output logic [NUM_FLOORS-1:0] pending_floors,
  output logic                  call_error
);
  localparam int FIW = $clog2(NUM_FLOORS);

  logic [1:0][NUM_FLOORS-1:0] pos;
  logic [1:0][FIW-1:0]        pos_idx;
  logic [1:0]                 pos_ok, idle, emerg, ack, elig;
  logic [FIW-1:0]             call_idx, tgt_idx, dist1, dist2;
  logic                       call_ok;

  state_e                     state_q, state_d;
  car_e                       winner_q, winner_d, pick;
  logic [NUM_FLOORS-1:0]      pending_q, pending_d;
  logic [1:0]                 valid_q, valid_d;
  logic [1:0][NUM_FLOORS-1:0] floor_q, floor_d;
  logic                       error_q, error_d;

  assign pos   = {current_floor_elevator2, current_floor_elevator1};
  assign idle  = {idle_elevator2, idle_elevator1};
  assign emerg = {in_emergency_elevator2, in_emergency_elevator1};
  assign ack   = {dispatch_ack_elevator2, dispatch_ack_elevator1};

  for (genvar c = 0; c < 2; c++) begin : g_car
    floor_encoder #(.W(NUM_FLOORS), .IW(FIW)) u_pos_enc (
      .onehot_i    (pos[c]),
      .idx_o       (pos_idx[c]),
      .onehot_ok_o (pos_ok[c])
    );
    assign elig[c] = idle[c] & ~emerg[c] & ~valid_q[c] & pos_ok[c];
  end

  floor_encoder #(.W(NUM_FLOORS), .IW(FIW)) u_call_enc (
    .onehot_i    (call_floor),
    .idx_o       (call_idx),
    .onehot_ok_o (call_ok)
  );

  // Lowest pending floor is served first
  always_comb begin
    tgt_idx = '0;
    for (int k = NUM_FLOORS - 1; k >= 0; k--)
      if (pending_q[k]) tgt_idx = FIW'(k);
  end

  assign dist1 = (tgt_idx >= pos_idx[0]) ? tgt_idx - pos_idx[0] : pos_idx[0] - tgt_idx;
  assign dist2 = (tgt_idx >= pos_idx[1]) ? tgt_idx - pos_idx[1] : pos_idx[1] - tgt_idx;

  always_comb begin
    case (elig)
      2'b10:   pick = CAR2;
      2'b11:   pick = (dist2 < dist1) ? CAR2 : CAR1;
      default: pick = CAR1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    pending_d = pending_q;
    valid_d   = valid_q;
    floor_d   = floor_q;
    error_d   = 1'b0;
    case (state_q)
      ST_IDLE:
        if ((pending_q != '0) && (elig != 2'b00)) state_d = ST_SELECT;
      ST_SELECT:
        if (elig == 2'b00) begin
          state_d = ST_IDLE;
        end else begin
          state_d            = ST_ISSUE;
          winner_d           = pick;
          pending_d[tgt_idx] = 1'b0;
          valid_d[pick]      = 1'b1;
          floor_d[pick]      = '0;
          floor_d[pick][tgt_idx] = 1'b1;
        end
      ST_ISSUE:
        if (ack[winner_q]) begin
          state_d           = ST_IDLE;
          valid_d[winner_q] = 1'b0;
          floor_d[winner_q] = '0;
        end else if (emerg[winner_q]) begin
          // Car pulled into emergency before accepting: put the call back
          state_d           = ST_IDLE;
          pending_d         = pending_d | floor_q[winner_q];
          valid_d[winner_q] = 1'b0;
          floor_d[winner_q] = '0;
        end
      default: state_d = ST_IDLE;
    endcase
    // New call applied last so a same-cycle set beats a clear
    if (call_valid) begin
      if (call_ok) pending_d[call_idx] = 1'b1;
      else         error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      winner_q  <= CAR1;
      pending_q <= '0;
      valid_q   <= '0;
      floor_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      floor_q   <= floor_d;
      error_q   <= error_d;
    end
  end

  assign dispatch_valid_elevator1 = valid_q[0];
  assign dispatch_valid_elevator2 = valid_q[1];
  assign dispatch_floor_elevator1 = floor_q[0];
  assign dispatch_floor_elevator2 = floor_q[1];
  assign pending_floors           = pending_q;
  assign call_error               = error_q;
endmodule

// File: tb/tb_elevator_dispatcher.sv
// Directed checks of call collection, car selection, handshake, emergency and reset.
module tb_elevator_dispatcher;
  localparam int NF = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          call_valid;
  logic [NF-1:0] call_floor;
  logic [NF-1:0] pos1, pos2;
  logic          idle1, idle2, emerg1, emerg2, ack1, ack2;
  logic          valid1, valid2, call_error;
  logic [NF-1:0] floor1, floor2, pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  elevator_dispatcher #(.NUM_FLOORS(NF)) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .call_valid               (call_valid),
    .call_floor               (call_floor),
    .current_floor_elevator1  (pos1),
    .current_floor_elevator2  (pos2),
    .idle_elevator1           (idle1),
    .idle_elevator2           (idle2),
    .in_emergency_elevator1   (emerg1),
    .in_emergency_elevator2   (emerg2),
    .dispatch_valid_elevator1 (valid1),
    .dispatch_valid_elevator2 (valid2),
    .dispatch_floor_elevator1 (floor1),
    .dispatch_floor_elevator2 (floor2),
    .dispatch_ack_elevator1   (ack1),
    .dispatch_ack_elevator2   (ack2),
    .pending_floors           (pending),
    .call_error               (call_error)
  );

  function automatic logic [NF-1:0] oh(input int floor_no);
    logic [NF-1:0] v;
    v = '0;
    v[floor_no - 1] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [NF-1:0] obs, input logic [NF-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic call(input logic [NF-1:0] f);
    call_valid = 1'b1;
    call_floor = f;
    tick();
    call_valid = 1'b0;
    call_floor = '0;
  endtask

  initial begin
    reset_n = 1'b0; call_valid = 1'b0; call_floor = '0;
    pos1 = oh(1); pos2 = oh(1);
    idle1 = 1'b1; idle2 = 1'b1; emerg1 = 1'b0; emerg2 = 1'b0;
    ack1 = 1'b0; ack2 = 1'b0;

    // Reset, with a call that must be ignored
    tick();
    call(oh(7));
    chk("rst_pending", pending, '0);
    chk("rst_valid1", NF'(valid1), '0);
    chk("rst_valid2", NF'(valid2), '0);
    chk("rst_floor1", floor1, '0);
    chk("rst_floor2", floor2, '0);
    chk("rst_err", NF'(call_error), '0);
    reset_n = 1'b1;
    tick();

    // Both cars at 1, call 10 -> car1, latency two edges after sampling
    call(oh(10));
    chk("t1_pend", pending, oh(10));
    chk("t1_v_n", NF'(valid1), '0);
    tick();
    chk("t1_v_n1", NF'(valid1), '0);
    tick();
    chk("t1_v_n2", NF'(valid1), NF'(1));
    chk("t1_floor", floor1, oh(10));
    chk("t1_pend_clr", pending, '0);
    chk("t1_v2", NF'(valid2), '0);
    chk("t1_f2", floor2, '0);
    tick();
    chk("t1_hold_v", NF'(valid1), NF'(1));
    chk("t1_hold_f", floor1, oh(10));
    ack1 = 1'b1; tick(); ack1 = 1'b0;
    chk("t1_ack_v", NF'(valid1), '0);
    chk("t1_ack_f", floor1, '0);
    tick();
    chk("t1_idle_v", NF'(valid1), '0);

    // Car1 at 10, car2 at 1, call 5: distances 5 vs 4 -> car2
    pos1 = oh(10); pos2 = oh(1);
    call(oh(5)); tick(); tick();
    chk("t2a_v2", NF'(valid2), NF'(1));
    chk("t2a_f2", floor2, oh(5));
    chk("t2a_v1", NF'(valid1), '0);
    ack2 = 1'b1; tick(); ack2 = 1'b0;
    chk("t2a_ack", NF'(valid2), '0);
    // Car2 now at 5, call 8: distances 2 vs 3 -> car1
    pos2 = oh(5);
    call(oh(8)); tick(); tick();
    chk("t2b_v1", NF'(valid1), NF'(1));
    chk("t2b_f1", floor1, oh(8));
    chk("t2b_v2", NF'(valid2), '0);
    ack1 = 1'b1; tick(); ack1 = 1'b0;
    // Tie: car1 at 3, car2 at 7, call 5 -> car1
    pos1 = oh(3); pos2 = oh(7);
    call(oh(5)); tick(); tick();
    chk("t2c_v1", NF'(valid1), NF'(1));
    chk("t2c_f1", floor1, oh(5));
    chk("t2c_v2", NF'(valid2), '0);
    ack1 = 1'b1; tick(); ack1 = 1'b0;

    // Car1 in emergency, both at 1, call 2 -> car2 only
    pos1 = oh(1); pos2 = oh(1); emerg1 = 1'b1;
    call(oh(2)); tick(); tick();
    chk("t3_v2", NF'(valid2), NF'(1));
    chk("t3_f2", floor2, oh(2));
    chk("t3_v1", NF'(valid1), '0);
    emerg2 = 1'b1; tick();
    chk("t3_em_v2", NF'(valid2), '0);
    chk("t3_em_f2", floor2, '0);
    chk("t3_em_pend", pending, oh(2));
    tick(); tick();
    chk("t3_none_pend", pending, oh(2));
    chk("t3_none_v1", NF'(valid1), '0);
    emerg1 = 1'b0; tick(); tick();
    chk("t3_re_v1", NF'(valid1), NF'(1));
    chk("t3_re_f1", floor1, oh(2));
    chk("t3_re_pend", pending, '0);
    ack2 = 1'b1; tick(); ack2 = 1'b0;
    chk("t3_stray_ack", NF'(valid1), NF'(1));
    ack1 = 1'b1; tick(); ack1 = 1'b0;
    chk("t3_ack", NF'(valid1), '0);
    emerg2 = 1'b0;

    // Malformed calls
    call(oh(2) | oh(4));
    chk("t4_err_multi", NF'(call_error), NF'(1));
    chk("t4_pend_multi", pending, '0);
    tick();
    chk("t4_err_pulse", NF'(call_error), '0);
    call('0);
    chk("t4_err_zero", NF'(call_error), NF'(1));
    chk("t4_pend_zero", pending, '0);
    tick();
    chk("t4_err_clr", NF'(call_error), '0);

    // Same floor re-called on the edge it is cleared: stays pending
    call(oh(3)); tick();
    call(oh(3));
    chk("t5_v1", NF'(valid1), NF'(1));
    chk("t5_f1", floor1, oh(3));
    chk("t5_pend", pending, oh(3));
    ack1 = 1'b1; tick(); ack1 = 1'b0;
    tick(); tick();
    chk("t5_again", floor1, oh(3));
    chk("t5_pend0", pending, '0);
    ack1 = 1'b1; tick(); ack1 = 1'b0;

    // Busy cars collect calls; lowest floor served first
    idle1 = 1'b0; idle2 = 1'b0;
    call(oh(12)); call(oh(2));
    chk("t6_pend", pending, oh(12) | oh(2));
    tick();
    chk("t6_pend_hold", pending, oh(12) | oh(2));
    chk("t6_nov", NF'({valid2, valid1}), '0);
    idle1 = 1'b1; tick(); tick();
    chk("t6_first", floor1, oh(2));
    chk("t6_pend_left", pending, oh(12));
    ack1 = 1'b1; tick(); ack1 = 1'b0;
    tick(); tick();
    chk("t6_second", floor1, oh(12));
    chk("t6_pend_empty", pending, '0);

    // Reset during ISSUE discards the assignment
    reset_n = 1'b0; tick();
    chk("t7_v1", NF'(valid1), '0);
    chk("t7_f1", floor1, '0);
    chk("t7_pend", pending, '0);
    chk("t7_err", NF'(call_error), '0);
    reset_n = 1'b1; ack1 = 1'b1; tick(); ack1 = 1'b0;
    chk("t7_ack_v1", NF'(valid1), '0);
    chk("t7_ack_f1", floor1, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
